// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, fetches over req/ack and holds one instruction behind valid/ready.
// Latency: ack in the first REQ cycle gives instr_valid the next cycle (2 cycles per instruction minimum).
// Backpressure: waits in REQ while imem_ack is low and in VALID while instr_ready is low; INSTR_FETCH_PERF_EN adds a stall counter.
module instr_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        BrTaken,
    input  logic        UncondBr,
    output logic [63:0] pc,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t      state;
    logic [63:0] br_off;
    logic [63:0] next_pc;

    // Branch offsets are word offsets, sign-extended and scaled to bytes.
    always_comb begin
        br_off  = UncondBr ? {{36{instr[25]}}, instr[25:0], 2'b00}
                           : {{43{instr[23]}}, instr[23:5], 2'b00};
        next_pc = pc + (BrTaken ? br_off : 64'd4);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= 32'h0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                end
                REQ: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        state       <= VALID;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                VALID: begin
                    if (instr_ready) begin
                        pc          <= next_pc;
                        state       <= REQ;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr = pc;

`ifdef INSTR_FETCH_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= 32'h0;
        end else if (((state == REQ) && !imem_ack) || ((state == VALID) && !instr_ready)) begin
            if (stall_cycles != 32'hFFFF_FFFF)
                stall_cycles <= stall_cycles + 32'd1;
        end
    end
`else
    assign stall_cycles = 32'h0;
`endif

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the single-cycle LEGv8 core. It sits directly upstream of the execution datapath and drives its 32-bit `OPCode` input. It owns the program counter and fetches from an instruction memory over a variable-latency req/ack handshake. It presents one instruction at a time with a valid/ready handshake, and computes the next PC from `BrTaken`/`UncondBr` when that instruction retires.

## Interface
- `RESET_PC`, default `64'h0`: PC loaded on reset.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  64  fetch address; always equal to `pc`.
- `imem_ack`  in  1  memory has returned data this cycle; `imem_rdata` is valid with it.
- `imem_rdata`  in  32  instruction word.
- `instr`  out  32  held instruction; drives the datapath `OPCode`.
- `instr_valid`  out  1  `instr` is valid.
- `instr_ready`  in  1  downstream retires `instr` at this edge.
- `BrTaken`  in  1  from CPUControl; sampled only on retire.
- `UncondBr`  in  1  from CPUControl; selects the BrAddr26 field over CondAddr19; sampled only on retire.
- `pc`  out  64  address of the current or held instruction.
- `stall_cycles`  out  32  stall counter (see Configuration).

## Operation
- FSM states: IDLE, REQ, VALID.
- IDLE: entered on reset. Unconditionally moves to REQ on the next edge.
- REQ: `imem_req=1`.
  - `imem_ack` low: stay in REQ.
  - `imem_ack` high: capture `instr<=imem_rdata` and move to VALID.
- VALID: `instr_valid=1` and `instr` is stable.
  - `instr_ready` low: stay in VALID.
  - `instr_ready` high: `pc<=next_pc` and move to REQ.
- `next_pc` selection:
  - `BrTaken=0`: `pc+4`.
  - `BrTaken=1, UncondBr=1`: `pc + (SE(instr[25:0])<<2)`.
  - `BrTaken=1, UncondBr=0`: `pc + (SE(instr[23:5])<<2)`.
- All PC arithmetic is 64-bit modulo 2^64 and wraps silently. `FFFF_FFFF_FFFF_FFFC + 4 = 0`.
- `imem_ack` outside REQ is ignored. A stale ack arriving after reset, while in IDLE, is dropped.
- `instr_ready` outside VALID is ignored. `BrTaken`/`UncondBr` are ignored except at the retire edge.
- Reset asserted in any state takes effect immediately:
  - state IDLE, `pc=RESET_PC`, `instr=0`, `stall_cycles=0`.
  - Any in-flight request is abandoned.

## Timing
- Reset values: `imem_req=0`, `imem_addr=RESET_PC`, `pc=RESET_PC`, `instr=32'h0`, `instr_valid=0`, `stall_cycles=0`.
- Startup: after reset deasserts, first edge goes IDLE->REQ, so `imem_req` is high in the second cycle.
- Fetch latency: if ack arrives in the first REQ cycle, `instr_valid` rises the next cycle.
- Minimum throughput: one instruction per 2 cycles (REQ, VALID) with zero-wait memory and `instr_ready` held high.
- Each memory wait state adds one REQ cycle. Each cycle of `instr_ready` low adds one VALID cycle.
- `imem_req`, `instr_valid` and `pc` are registered state decodes, with no combinational path from inputs.
- `BrTaken`/`UncondBr` must settle combinationally from `instr` before the retire edge.

## Configuration
- `INSTR_FETCH_PERF_EN` defined:
  - `stall_cycles` increments each cycle in REQ with `imem_ack=0`.
  - It also increments each cycle in VALID with `instr_ready=0`.
  - It saturates at `32'hFFFF_FFFF` and clears only on reset.
- `INSTR_FETCH_PERF_EN` not defined: `stall_cycles` is tied to `32'h0` and no counter register exists.

## Test plan
- Reset release, zero-wait memory, `instr_ready=1`, `BrTaken=0` -> `imem_addr` sequence 0x0, 0x4, 0x8 on alternate cycles; `instr_valid` pulses every second cycle.
- Memory acks 3 cycles after request -> `instr_valid` rises 4 cycles after `imem_req`. With PERF_EN, `stall_cycles=3` after the first fetch.
- B at `pc=0x10`, `instr[25:0]=26'h3FFFFFE`, `UncondBr=1`, `BrTaken=1` -> next `imem_addr=0x08`.
- CBZ at `pc=0x20` with `instr[23:5]=3`, `UncondBr=0`:
  - `BrTaken=1` -> next 0x2C.
  - Repeated with `BrTaken=0` -> next 0x24.
- `RESET_PC=64'hFFFF_FFFF_FFFF_FFFC`, sequential retire -> next `imem_addr=0x0`.
- Reset asserted mid-REQ, then a late `imem_ack` with data 0xDEADBEEF -> `instr` stays 0 and `instr_valid=0`. Fetch restarts at `RESET_PC`.
